// File: rtl/puf_challenge_ctrl.sv
// Arbiter-PUF challenge controller: LFSR challenges, launch/settle/sample sequencing,
// and packing of synchronised response bits into a word on a valid/ready port.
module puf_challenge_ctrl #(
    parameter int            N             = 128,
    parameter int            RESP_BITS     = 32,
    parameter int            SETTLE_CYCLES = 4,
    parameter logic [N-1:0]  SEED          = {{(N-1){1'b0}}, 1'b1}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 seed_load,
    input  logic [N-1:0]         seed,
    output logic                 busy,
    output logic [N-1:0]         puf_sel,
    output logic                 puf_in,
    output logic                 puf_reset,
    input  logic                 puf_out,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2:0]           state_dbg
);

    // Response handshake: resp_data is held stable while resp_valid is high; the word
    // is consumed on a clock edge where resp_valid && resp_ready, after which
    // resp_valid is low on the following cycle.

    localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BIT    = BW'(RESP_BITS - 1);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [N-1:0]  ONE         = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  SEED_EFF    = (SEED == '0) ? ONE : SEED;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LAUNCH = 3'd2,
        S_SETTLE = 3'd3,
        S_SAMPLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 state, next_state;
    logic [N-1:0]           lfsr;
    logic [1:0]             sync_q;
    logic [BW-1:0]          bit_cnt;
    logic [SW-1:0]          settle_cnt;
    logic [RESP_BITS-1:0]   resp_shift;
    logic                   launch_d;
    logic                   fb;

    assign fb        = lfsr[N-1] ^ lfsr[6] ^ lfsr[1] ^ lfsr[0];
    assign puf_sel   = lfsr;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_comb begin
        next_state = state;
        launch_d   = 1'b0;
        case (state)
            S_IDLE:   if (start) next_state = S_CLEAR;
            S_CLEAR:  next_state = S_LAUNCH;
            S_LAUNCH: next_state = S_SETTLE;
            S_SETTLE: if (settle_cnt == '0) next_state = S_SAMPLE;
            S_SAMPLE: next_state = (bit_cnt == LAST_BIT) ? S_DONE : S_CLEAR;
            S_DONE:   if (resp_valid && resp_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        // Chain input stays high from launch through sample so the arbiter holds its decision.
        if (next_state == S_LAUNCH || next_state == S_SETTLE || next_state == S_SAMPLE)
            launch_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            lfsr       <= SEED_EFF;
            sync_q     <= '0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            resp_shift <= '0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
            puf_in     <= 1'b0;
            puf_reset  <= 1'b1;
        end else begin
            state     <= next_state;
            sync_q    <= {sync_q[0], puf_out};
            puf_in    <= launch_d;
            puf_reset <= ~launch_d;
            case (state)
                S_IDLE: begin
                    if (seed_load) lfsr <= (seed == '0) ? ONE : seed;
                    if (start) bit_cnt <= '0;
                end
                S_LAUNCH: settle_cnt <= SETTLE_INIT;
                S_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                S_SAMPLE: begin
                    resp_shift <= {resp_shift[RESP_BITS-2:0], sync_q[1]};
                    lfsr       <= {lfsr[N-2:0], fb};
                    bit_cnt    <= bit_cnt + 1'b1;
                end
                S_DONE: begin
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                    end else if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_data  <= resp_shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Directed bench for puf_challenge_ctrl with a behavioural arbiter-PUF model that
// latches puf_sel[0] on the rising launch edge and clears on puf_reset.
module tb_puf_challenge_ctrl;

    localparam int N   = 128;
    localparam int RB  = 8;
    localparam int SET = 4;
    localparam int LATENCY = RB * (SET + 3) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          seed_load;
    logic [N-1:0]  seed;
    logic          busy;
    logic [N-1:0]  puf_sel;
    logic          puf_in;
    logic          puf_reset;
    logic          puf_out;
    logic [RB-1:0] resp_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [2:0]    state_dbg;

    int checks   = 0;
    int failures = 0;
    int puf_rises = 0;

    logic puf_latch = 1'b0;

    puf_challenge_ctrl #(.N(N), .RESP_BITS(RB), .SETTLE_CYCLES(SET)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .seed_load(seed_load), .seed(seed),
        .busy(busy), .puf_sel(puf_sel), .puf_in(puf_in), .puf_reset(puf_reset),
        .puf_out(puf_out), .resp_data(resp_data), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge puf_in or posedge puf_reset) begin
        if (puf_reset) puf_latch <= 1'b0;
        else           puf_latch <= puf_sel[0];
    end
    assign puf_out = puf_latch;

    always @(posedge puf_in) puf_rises++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start (optionally with seed_load) and waits for resp_valid.
    task automatic run_word(input logic ld, input logic [N-1:0] sd, output int edges,
                            output int busy_low, output int rises, output logic [RB-1:0] data);
        int r0;
        seed_load = ld;
        seed      = sd;
        start     = 1'b1;
        r0        = puf_rises;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
        edges     = 0;
        busy_low  = 0;
        while (!resp_valid && edges < 200) begin
            if (!busy) busy_low++;
            tick();
            edges++;
        end
        data  = resp_data;
        rises = puf_rises - r0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start     = i[0];
            seed_load = ~i[0];
            seed      = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        start = 1'b0; seed_load = 1'b0;
        checks++; if (puf_reset !== 1'b1) begin failures++; $display("FAIL reset_puf_reset got=%b exp=1", puf_reset); end
        checks++; if (puf_in !== 1'b0) begin failures++; $display("FAIL reset_puf_in got=%b exp=0", puf_in); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_data !== 8'h00) begin failures++; $display("FAIL reset_resp_data got=%h exp=00", resp_data); end
        checks++; if (puf_sel !== 128'd1) begin failures++; $display("FAIL reset_puf_sel got=%h exp=1", puf_sel); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_known_sequence();
        int edges, busy_low, rises, vcnt;
        logic [RB-1:0] data;
        resp_ready = 1'b1;
        run_word(1'b1, 128'd1, edges, busy_low, rises, data);
        checks++; if (data !== 8'hDA) begin failures++; $display("FAIL known_data got=%h exp=da", data); end
        checks++; if (edges !== LATENCY) begin failures++; $display("FAIL known_latency got=%0d exp=%0d", edges, LATENCY); end
        checks++; if (busy_low !== 0) begin failures++; $display("FAIL known_busy_gaps got=%0d exp=0", busy_low); end
        checks++; if (rises !== RB) begin failures++; $display("FAIL known_launch_edges got=%0d exp=%0d", rises, RB); end
        vcnt = 0;
        while (resp_valid && vcnt < 20) begin
            vcnt++;
            tick();
        end
        checks++; if (vcnt !== 1) begin failures++; $display("FAIL known_valid_pulse got=%0d exp=1", vcnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL known_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int edges, busy_low, rises, bad;
        logic [RB-1:0] data;
        resp_ready = 1'b0;
        run_word(1'b1, 128'd1, edges, busy_low, rises, data);
        checks++; if (data !== 8'hDA) begin failures++; $display("FAIL bp_data got=%h exp=da", data); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start     = (i == 3);
            seed_load = (i == 3);
            seed      = 128'd5;
            if (!resp_valid || resp_data !== 8'hDA || state_dbg !== 3'd5) bad++;
            tick();
        end
        start = 1'b0; seed_load = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_held got=%b exp=1", resp_valid); end
        resp_ready = 1'b1;
        tick();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got=%b exp=0", resp_valid); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL bp_idle got=%0d exp=0", state_dbg); end
        run_word(1'b0, 128'd0, edges, busy_low, rises, data);
        checks++; if (data !== 8'h2B) begin failures++; $display("FAIL bp_second_word got=%h exp=2b", data); end
        checks++; if (edges !== LATENCY) begin failures++; $display("FAIL bp_second_latency got=%0d exp=%0d", edges, LATENCY); end
        tick();
    endtask

    task automatic test_zero_seed();
        int edges, busy_low, rises;
        logic [RB-1:0] data;
        resp_ready = 1'b1;
        run_word(1'b1, 128'd0, edges, busy_low, rises, data);
        checks++; if (data !== 8'hDA) begin failures++; $display("FAIL zero_seed_data got=%h exp=da", data); end
        checks++; if (rises !== RB) begin failures++; $display("FAIL zero_seed_edges got=%0d exp=%0d", rises, RB); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int r0, n, vseen, edges, busy_low, rises;
        logic [RB-1:0] data;
        resp_ready = 1'b1;
        seed_load  = 1'b1;
        seed       = 128'hA5;
        start      = 1'b1;
        r0         = puf_rises;
        tick();
        start = 1'b0; seed_load = 1'b0;
        n = 0;
        while ((puf_rises - r0) < 4 && n < 200) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++; if (state_dbg !== 3'd3) begin failures++; $display("FAIL mid_in_settle got=%0d exp=3", state_dbg); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (puf_reset !== 1'b1 || puf_in !== 1'b0) begin failures++; $display("FAIL mid_puf_ctrl got=%b%b exp=10", puf_reset, puf_in); end
        checks++; if (puf_sel !== 128'd1) begin failures++; $display("FAIL mid_lfsr got=%h exp=1", puf_sel); end
        vseen = 0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid) vseen++;
            tick();
        end
        checks++; if (vseen !== 0) begin failures++; $display("FAIL mid_no_valid got=%0d exp=0", vseen); end
        reset_n = 1'b1;
        tick();
        run_word(1'b0, 128'd0, edges, busy_low, rises, data);
        checks++; if (data !== 8'hDA) begin failures++; $display("FAIL mid_restart_data got=%h exp=da", data); end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        seed_load  = 1'b0;
        seed       = '0;
        resp_ready = 1'b1;
        test_reset();
        test_known_sequence();
        test_back_to_back();
        test_zero_seed();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
